// File: rtl/baggage_drop_if.sv
// Handshake and data bundle between the baggage-drop sequencer and its host.
// The host (master) drives the request side; the controller (slave) drives status and results.
interface baggage_drop_if;
  logic        start;
  logic [7:0]  sensor1;
  logic [7:0]  sensor2;
  logic [7:0]  sensor3;
  logic [7:0]  sensor4;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        busy;
  logic        done;
  logic [15:0] t_act;
  logic        t_act_valid;
  logic        drop_activated;

  modport master (
    output start, sensor1, sensor2, sensor3, sensor4, t_lim, drop_en,
    input  busy, done, t_act, t_act_valid, drop_activated
  );

  modport slave (
    input  start, sensor1, sensor2, sensor3, sensor4, t_lim, drop_en,
    output busy, done, t_act, t_act_valid, drop_activated
  );
endinterface

// File: rtl/baggage_drop_ctrl.sv
// Sequenced baggage-drop decision: averages four height sensors, takes a 12-step
// bit-serial square root of height*65536, compares the fall time and holds a drop command.
module baggage_drop_ctrl #(
  parameter int unsigned DROP_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  baggage_drop_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SQRT, DROP} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(DROP_HOLD - 1);

  state_t      state_reg;
  logic [7:0]  s1_reg, s2_reg, s3_reg, s4_reg;
  logic [15:0] t_lim_reg;
  logic        drop_en_reg;
  logic [11:0] root_reg;
  logic [13:0] rem_reg;
  logic [3:0]  iter_reg;
  logic [7:0]  hold_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        valid_reg;
  logic        drop_reg;
  logic [15:0] t_act_reg;

  logic [9:0]  sum;
  logic [7:0]  height;
  logic [23:0] radicand;
  logic [4:0]  pair_idx;
  logic [15:0] rem_shift;
  logic [15:0] trial;
  logic        fits;
  logic [11:0] root_next;
  logic [13:0] rem_next;
  logic [15:0] t_act_new;
  logic        decision;

  assign sum      = {2'b00, s1_reg} + {2'b00, s2_reg} + {2'b00, s3_reg} + {2'b00, s4_reg};
  assign height   = sum[9:2];
  assign radicand = {height, 16'h0000};
  assign pair_idx = {iter_reg, 1'b0};

  // Restoring step: bring down the next radicand bit pair and try subtracting 4*root+1.
  assign rem_shift = {rem_reg, radicand[pair_idx +: 2]};
  assign trial     = {2'b00, root_reg, 2'b01};
  assign fits      = (rem_shift >= trial);
  assign root_next = {root_reg[10:0], fits};
  // The true remainder always fits in 14 bits, so modular subtraction on the low bits is exact.
  assign rem_next  = fits ? (rem_shift[13:0] - trial[13:0]) : rem_shift[13:0];

  assign t_act_new = {5'b00000, root_next[11:1]};
  assign decision  = drop_en_reg && (t_act_new <= t_lim_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      s1_reg      <= '0;
      s2_reg      <= '0;
      s3_reg      <= '0;
      s4_reg      <= '0;
      t_lim_reg   <= '0;
      drop_en_reg <= 1'b0;
      root_reg    <= '0;
      rem_reg     <= '0;
      iter_reg    <= '0;
      hold_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      drop_reg    <= 1'b0;
      t_act_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            s1_reg      <= bus.sensor1;
            s2_reg      <= bus.sensor2;
            s3_reg      <= bus.sensor3;
            s4_reg      <= bus.sensor4;
            t_lim_reg   <= bus.t_lim;
            drop_en_reg <= bus.drop_en;
            root_reg    <= '0;
            rem_reg     <= '0;
            iter_reg    <= 4'd11;
            busy_reg    <= 1'b1;
            state_reg   <= SQRT;
          end
        end
        SQRT: begin
          root_reg <= root_next;
          rem_reg  <= rem_next;
          iter_reg <= iter_reg - 4'd1;
          if (iter_reg == 4'd0) begin
            t_act_reg <= t_act_new;
            done_reg  <= 1'b1;
            valid_reg <= 1'b1;
            if (decision) begin
              drop_reg  <= 1'b1;
              hold_reg  <= HOLD_LOAD;
              state_reg <= DROP;
            end else begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        DROP: begin
          if (hold_reg == 8'd0) begin
            drop_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            hold_reg <= hold_reg - 8'd1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          drop_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy           = busy_reg;
  assign bus.done           = done_reg;
  assign bus.t_act          = t_act_reg;
  assign bus.t_act_valid    = valid_reg;
  assign bus.drop_activated = drop_reg;

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// Scoreboard bench for baggage_drop_ctrl: expected fall time and drop decision are queued
// at each accept and compared when done pulses; phase lengths are measured per operation.
module tb_baggage_drop_ctrl;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  baggage_drop_if bus ();

  baggage_drop_ctrl #(.DROP_HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [15:0] t;
    logic        drop;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Independent reference: floor(sqrt(height*65536)) by binary search, then halved.
  function automatic logic [15:0] model_t(input logic [7:0] a, b, c, d);
    int h, r, lo, hi, mid;
    h  = (int'(a) + int'(b) + int'(c) + int'(d)) / 4;
    r  = h * 65536;
    lo = 0;
    hi = 4096;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= r) lo = mid;
      else hi = mid;
    end
    return 16'(lo / 2);
  endfunction

  task automatic push_exp(input logic [7:0] a, b, c, d, input logic [15:0] tl,
                          input logic de, output logic dr);
    exp_t e;
    e.t    = model_t(a, b, c, d);
    e.drop = de && (e.t <= tl);
    dr     = e.drop;
    sb.push_back(e);
  endtask

  task automatic drive_inputs(input logic [7:0] a, b, c, d, input logic [15:0] tl, input logic de);
    bus.sensor1 = a;
    bus.sensor2 = b;
    bus.sensor3 = c;
    bus.sensor4 = d;
    bus.t_lim   = tl;
    bus.drop_en = de;
  endtask

  task automatic scramble_inputs();
    drive_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 16'($urandom), 1'($urandom));
  endtask

  // One full operation: accept, then measure busy length, drop length and done position.
  task automatic run_op(input logic [7:0] a, b, c, d, input logic [15:0] tl,
                        input logic de, input string tag);
    int   n, busy_n, drop_n, done_at;
    logic dr;
    @(negedge clk);
    n = 0;
    while (bus.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check({tag, "_idle_timeout"}, 1, 0);
    drive_inputs(a, b, c, d, tl, de);
    bus.start = 1'b1;
    push_exp(a, b, c, d, tl, de, dr);
    @(negedge clk);
    bus.start = 1'b0;
    scramble_inputs();
    busy_n  = 0;
    drop_n  = 0;
    done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.busy) busy_n++;
      if (bus.drop_activated) drop_n++;
      if (bus.done) done_at = k;
      if (!bus.busy) break;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, busy_n, dr ? 12 + HOLD : 12);
    check({tag, "_drop_len"}, drop_n, dr ? HOLD : 0);
    check({tag, "_done_at"}, done_at, 12);
  endtask

  // Scoreboard consumer and t_act hold check.
  initial begin
    logic [15:0] last_t;
    exp_t        e;
    last_t = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_t = '0;
      end else if (bus.done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("t_act", bus.t_act, e.t);
          check("drop_at_done", bus.drop_activated, e.drop);
          check("t_act_valid", bus.t_act_valid, 1);
        end
        last_t = bus.t_act;
      end else begin
        check("t_act_hold", bus.t_act, last_t);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   n_done;
    logic prev_idle;
    logic dr;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    drive_inputs(8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_t_act", bus.t_act, 0);
    check("rst_valid", bus.t_act_valid, 0);
    check("rst_drop", bus.drop_activated, 0);
    rst_n = 1'b1;

    run_op(8'd100, 8'd100, 8'd100, 8'd100, 16'd1280, 1'b1, "nominal");
    run_op(8'd100, 8'd100, 8'd100, 8'd100, 16'd1279, 1'b1, "lim_below");
    run_op(8'd100, 8'd100, 8'd100, 8'd100, 16'd1280, 1'b0, "drop_off");
    run_op(8'd255, 8'd255, 8'd255, 8'd255, 16'hFFFF, 1'b1, "max");
    run_op(8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 1'b1, "zero");
    run_op(8'd3, 8'd0, 8'd0, 8'd0, 16'd0, 1'b1, "trunc");
    run_op(8'd10, 8'd20, 8'd30, 8'd41, 16'd639, 1'b1, "avg_below");
    run_op(8'd10, 8'd20, 8'd30, 8'd41, 16'd640, 1'b1, "avg_eq");

    // Asynchronous reset in the middle of the root phase.
    @(negedge clk);
    drive_inputs(8'd100, 8'd100, 8'd100, 8'd100, 16'd1280, 1'b1);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_t_act", bus.t_act, 0);
    check("mrst_valid", bus.t_act_valid, 0);
    check("mrst_drop", bus.drop_activated, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("mrst_no_done", n_done, 0);
    run_op(8'd50, 8'd60, 8'd70, 8'd80, 16'hFFFF, 1'b1, "post_rst");

    // start held high with inputs changing every cycle.
    prev_idle = 1'b0;
    for (int k = 0; k < 70; k++) begin
      if (k > 0) @(negedge clk);
      if (prev_idle) check("b2b_accept", bus.busy, 1);
      if (k == 69) begin
        bus.start = 1'b0;
        break;
      end
      drive_inputs(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   16'($urandom_range(0, 2100)), 1'($urandom_range(0, 3) != 0));
      bus.start = 1'b1;
      if (!bus.busy) push_exp(bus.sensor1, bus.sensor2, bus.sensor3, bus.sensor4,
                              bus.t_lim, bus.drop_en, dr);
      prev_idle = !bus.busy;
    end

    repeat (4) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             16'($urandom_range(0, 2100)), 1'($urandom_range(0, 1)), "random");
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
